feature_frame_loader: RTL and testbench

Upstream feeder for the combinational `neural_net` classifier.
- Accepts a serial stream of IEEE-754 single-precision feature words over a valid/ready handshake.
- Assembles them into a 16-entry parallel frame that drives `X_1`..`X_16`.
- Holds the frame stable for a fixed settle window so the multicycle float datapath resolves, then presents it to the downstream result-capture logic with a valid/ack handshake.
- Detects malformed frames and drops them.

---
 rtl/feature_frame_loader_if.sv | 27 ++
 rtl/feature_frame_loader.sv | 156 +++++++++++++++
 tb/tb_feature_frame_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_frame_loader_if.sv
// Bus bundle for feature_frame_loader: serial feature-word input stream,
// parallel frame output and the downstream present/ack handshake.
// master = upstream feeder + result consumer, slave = the loader itself.
interface feature_frame_loader_if #(
    parameter int N_FEAT = 16
) ();
    logic [31:0]          in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [32*N_FEAT-1:0] feat_flat;
    logic                 frame_valid;
    logic                 frame_ack;
    logic                 frame_err;
    logic [1:0]           err_code;
    logic [15:0]          frame_cnt;

    modport master (
        output in_data, in_valid, in_last, frame_ack,
        input  in_ready, feat_flat, frame_valid, frame_err, err_code, frame_cnt
    );

    modport slave (
        input  in_data, in_valid, in_last, frame_ack,
        output in_ready, feat_flat, frame_valid, frame_err, err_code, frame_cnt
    );
endinterface

// File: rtl/feature_frame_loader.sv
// feature_frame_loader: collects N_FEAT serial IEEE-754 words into a parallel
// frame for the neural_net classifier, holds it for SETTLE_CYCLES so the float
// datapath resolves, then presents it until the consumer acknowledges.
// Malformed frames (short, long, and - with FEATURE_NAN_CHECK_EN defined -
// frames containing NaN/Inf words) are dropped with a frame_err pulse.
//
// Handshakes: an input word transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is decoded from the registered state only.
// frame_valid is high in PRESENT; frame_ack sampled high while frame_valid is
// high releases the frame. frame_ack is ignored at all other times.
module feature_frame_loader #(
    parameter int N_FEAT        = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    feature_frame_loader_if.slave   bus,
    output logic [1:0]              dbg_state_o
);
    localparam int IDX_W = $clog2(N_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_DRAIN   = 2'd1,
        S_SETTLE  = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [32*N_FEAT-1:0] feat_q, feat_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic [15:0]          fcnt_q, fcnt_d;
    logic                 bad_q, bad_d;
    logic                 in_ready;
    logic                 xfer;
    logic                 word_bad;
    logic                 bad_nxt;

`ifdef FEATURE_NAN_CHECK_EN
    // Exponent all-ones marks NaN or +/-Inf.
    assign word_bad = &bus.in_data[30:23];
`else
    assign word_bad = 1'b0;
`endif

    // Ready only while collecting or draining; held low during reset.
    assign in_ready = rst_n && ((state_q == S_LOAD) || (state_q == S_DRAIN));
    assign xfer     = bus.in_valid && in_ready;

    assign bus.in_ready    = in_ready;
    assign bus.feat_flat   = feat_q;
    assign bus.frame_valid = (state_q == S_PRESENT);
    assign bus.frame_err   = err_q;
    assign bus.err_code    = code_q;
    assign bus.frame_cnt   = fcnt_q;
    assign dbg_state_o     = state_q;

    // Next-state and datapath updates for the frame FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        feat_d  = feat_q;
        err_d   = 1'b0;
        code_d  = code_q;
        fcnt_d  = fcnt_q;
        bad_d   = bad_q;
        bad_nxt = bad_q | word_bad;

        case (state_q)
            S_LOAD: begin
                if (xfer) begin
                    feat_d[int'(idx_q)*32 +: 32] = bus.in_data;
                    if (idx_q != LAST_IDX) begin
                        if (bus.in_last) begin
                            // Short frame: drop it and restart collection.
                            err_d  = 1'b1;
                            code_d = 2'b01;
                            idx_d  = '0;
                            bad_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            bad_d = bad_nxt;
                        end
                    end else if (bus.in_last) begin
                        idx_d = '0;
                        bad_d = 1'b0;
                        if (bad_nxt) begin
                            // Complete but contains a non-finite word.
                            err_d  = 1'b1;
                            code_d = 2'b11;
                        end else begin
                            state_d = S_SETTLE;
                            cnt_d   = 8'(SETTLE_CYCLES - 1);
                        end
                    end else begin
                        // Long frame: flag now, swallow the rest in DRAIN.
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        bad_d   = 1'b0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer && bus.in_last) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_PRESENT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PRESENT: begin
                if (bus.frame_ack) begin
                    fcnt_d  = fcnt_q + 16'd1;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and output registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            feat_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            fcnt_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            feat_q  <= feat_d;
            err_q   <= err_d;
            code_q  <= code_d;
            fcnt_q  <= fcnt_d;
            bad_q   <= bad_d;
        end
    end
endmodule

// File: tb/tb_feature_frame_loader.sv
// Bench for feature_frame_loader: directed frames followed by random frames.
// A frame-level reference model (slot array + length/content rules) pushes
// expected frames and error codes into queues; a negedge monitor pops them
// whenever the DUT presents a frame or pulses frame_err.
module tb_feature_frame_loader;
    localparam int N_FEAT = 16;
    localparam int SETTLE = 4;
    localparam int W      = 32 * N_FEAT;
`ifdef FEATURE_NAN_CHECK_EN
    localparam bit NAN_EN = 1'b1;
`else
    localparam bit NAN_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    feature_frame_loader_if #(.N_FEAT(N_FEAT)) bus ();

    feature_frame_loader #(
        .N_FEAT        (N_FEAT),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [1:0]   err_q[$];
    logic [31:0]  model[N_FEAT];
    logic [31:0]  words[$];
    int           n_pass   = 0;
    int           n_total  = 0;
    int           pres_cnt = 0;
    int           last_cyc = 0;
    bit           ack_mode = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [W-1:0] pack_model();
        logic [W-1:0] f;
        for (int i = 0; i < N_FEAT; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    function automatic logic [31:0] rand_finite();
        logic [31:0] v;
        v = $urandom;
        if (v[30:23] == 8'hFF) v[30] = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] rand_nonfinite();
        logic [31:0] v;
        v = $urandom;
        v[30:23] = 8'hFF;
        return v;
    endfunction

    // ---------------- consumer: random acks (ignored outside PRESENT) ----------------
    always @(negedge clk) begin
        if (ack_mode) bus.frame_ack = ($urandom_range(0, 2) == 0);
    end

    // ---------------- monitor ----------------
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_valid", 1, 0);
                end else begin
                    check("frame_data", bus.feat_flat, exp_q.pop_front());
                    check("settle_latency", W'(cyc - last_cyc), W'(SETTLE));
                    check("frame_cnt_at_present", W'(bus.frame_cnt), W'(pres_cnt[15:0]));
                    pres_cnt++;
                end
            end
            if (bus.frame_err) begin
                if (err_q.size() == 0) check("unexpected_frame_err", 1, 0);
                else check("err_code", W'(bus.err_code), W'(err_q.pop_front()));
            end
        end
        prev_valid = bus.frame_valid;
    end

    // ---------------- driver tasks ----------------
    // Presents one word at a negedge and returns after the edge that takes it.
    task automatic put_word(input logic [31:0] d, input logic last, output bit ok);
        int tmo = 0;
        ok = 1'b1;
        @(negedge clk);
        while ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready) begin
            @(negedge clk);
            tmo++;
            if (tmo > 200) begin
                fail_now("in_ready_wait");
                bus.in_valid = 1'b0;
                ok = 1'b0;
                return;
            end
        end
        if (last) last_cyc = cyc + 1;
        @(posedge clk);
    endtask

    // Applies the frame rules to the model, queues expectations, sends 'words'.
    task automatic send_frame();
        int  len;
        int  n_wr;
        bit  nonfinite;
        bit  ok;
        len  = words.size();
        n_wr = (len < N_FEAT) ? len : N_FEAT;
        nonfinite = 1'b0;
        for (int i = 0; i < n_wr; i++) begin
            model[i] = words[i];
            if (words[i][30:23] == 8'hFF) nonfinite = 1'b1;
        end
        if (len < N_FEAT)             err_q.push_back(2'b01);
        else if (len > N_FEAT)        err_q.push_back(2'b10);
        else if (NAN_EN && nonfinite) err_q.push_back(2'b11);
        else                          exp_q.push_back(pack_model());
        for (int i = 0; i < len; i++) begin
            put_word(words[i], (i == len - 1), ok);
            if (!ok) return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int tmo = 0;
        while (!bus.frame_valid) begin
            @(negedge clk);
            tmo++;
            if (tmo > 100) begin
                fail_now("frame_valid_wait");
                return;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ones[N_FEAT];
        bit ok;
        int len, nan_pos, tmo;
        ones = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                 32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        for (int i = 0; i < N_FEAT; i++) model[i] = 32'h0;

        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", W'(bus.in_ready), 0);
        check("reset_feat_flat", bus.feat_flat, 0);
        check("reset_frame_valid", W'(bus.frame_valid), 0);
        check("reset_frame_err", W'(bus.frame_err), 0);
        check("reset_err_code", W'(bus.err_code), 0);
        check("reset_frame_cnt", W'(bus.frame_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", W'(bus.in_ready), 1);

        // Frame of 1.0 .. 16.0, then hold the ack off for 10 cycles.
        words.delete();
        for (int i = 0; i < N_FEAT; i++) words.push_back(ones[i]);
        send_frame();
        wait_valid();
        check("slot0", W'(bus.feat_flat[31:0]), W'(32'h3F800000));
        check("slot15", W'(bus.feat_flat[W-1 -: 32]), W'(32'h41800000));
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            bus.in_last  = $urandom_range(0, 1);
            check("hold_in_ready", W'(bus.in_ready), 0);
            check("hold_feat_flat", bus.feat_flat, pack_model());
            @(negedge clk);
        end
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        check("ack_frame_valid", W'(bus.frame_valid), 0);
        check("ack_in_ready", W'(bus.in_ready), 1);
        check("ack_frame_cnt", W'(bus.frame_cnt), 1);
        ack_mode = 1'b1;

        // Short frame of 5 words, then a normal frame.
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back(rand_finite());
        send_frame();
        check("short_err_pulse", W'(bus.frame_err), 1);
        @(negedge clk);
        check("short_err_one_cycle", W'(bus.frame_err), 0);
        words.delete();
        for (int i = 0; i < N_FEAT; i++) words.push_back(rand_finite());
        send_frame();

        // Long frame of 20 words: the extra words must not reach the frame.
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(rand_finite());
        send_frame();
        check("long_slot0_kept", W'(bus.feat_flat[31:0]), W'(words[0]));
        check("long_frame_contents", bus.feat_flat, pack_model());
        words.delete();
        for (int i = 0; i < N_FEAT; i++) words.push_back(rand_finite());
        send_frame();

        // Word 7 is a quiet NaN.
        words.delete();
        for (int i = 0; i < N_FEAT; i++) words.push_back(rand_finite());
        words[6] = 32'h7FC00000;
        send_frame();

        // Random frames: mostly well formed, some short/long, some non-finite.
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 9))
                0, 1:    len = $urandom_range(1, N_FEAT - 1);
                2:       len = $urandom_range(N_FEAT + 1, N_FEAT + 6);
                default: len = N_FEAT;
            endcase
            nan_pos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            words.delete();
            for (int i = 0; i < len; i++)
                words.push_back((i == nan_pos) ? rand_nonfinite() : rand_finite());
            send_frame();
        end

        // Drain outstanding expectations.
        tmo = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && tmo < 1000) begin
            @(negedge clk);
            tmo++;
        end
        if (exp_q.size() != 0 || err_q.size() != 0) fail_now("scoreboard_drain");
        repeat (20) @(negedge clk);

        // Reset after word 9 of a frame.
        for (int i = 0; i < 9; i++) begin
            put_word(rand_finite(), 1'b0, ok);
            if (!ok) break;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        ack_mode     = 1'b0;
        bus.frame_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_in_ready", W'(bus.in_ready), 0);
        check("midreset_feat_flat", bus.feat_flat, 0);
        check("midreset_frame_valid", W'(bus.frame_valid), 0);
        check("midreset_frame_err", W'(bus.frame_err), 0);
        check("midreset_err_code", W'(bus.err_code), 0);
        check("midreset_frame_cnt", W'(bus.frame_cnt), 0);
        for (int i = 0; i < N_FEAT; i++) model[i] = 32'h0;
        pres_cnt = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        ack_mode = 1'b1;
        words.delete();
        for (int i = 0; i < N_FEAT; i++) words.push_back(rand_finite());
        send_frame();
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 200) begin
            @(negedge clk);
            tmo++;
        end
        if (exp_q.size() != 0) fail_now("post_reset_frame");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
